ext_code_loader: RTL



---
 rtl/ext_code_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ext_code_loader.sv
// Framed host-command loader for the external code table.
// Drives index/code/trigger strobes with programmable setup, pulse and hold.
module ext_code_loader #(
   parameter int SETUP_CYC   = 2,
   parameter int PULSE_CYC   = 4,
   parameter int HOLD_CYC    = 2,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic [7:0]  iRx_data,
   input  logic        iRx_valid,
   output logic        oRx_ready,
   output logic        oSET_INDEX_FLAG,
   output logic [7:0]  oSET_INDEX,
   output logic        oSET_CODE_FLAG,
   output logic [31:0] oSET_CODE,
   output logic        oTrigger,
   output logic        oErr,
   output logic [15:0] oCmd_count
);

   typedef enum logic [2:0] {
      IDLE, PAYLOAD, SETUP, PULSE, HOLD
   } state_t;

   typedef enum logic [1:0] {
      K_IDX, K_CODE, K_TRIG
   } kind_t;

   localparam int PMAX =
      (SETUP_CYC > PULSE_CYC) ?
      ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
      ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
   localparam int PW = $clog2(PMAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [PW-1:0] S_LAST = PW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYC - 1);
   localparam logic [PW-1:0] H_LAST = PW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   state_t        state;
   kind_t         kind;
   logic [PW-1:0] phase;
   logic [TW-1:0] idle_cnt;
   logic [2:0]    left;
   logic [31:0]   shreg;
   logic          take;
   logic [31:0]   shifted;

   assign take    = iRx_valid & oRx_ready;
   assign shifted = (shreg << 8) | {24'd0, iRx_data};

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state           <= IDLE;
         kind            <= K_IDX;
         phase           <= '0;
         idle_cnt        <= '0;
         left            <= '0;
         shreg           <= '0;
         oRx_ready       <= 1'b0;
         oSET_INDEX_FLAG <= 1'b0;
         oSET_INDEX      <= '0;
         oSET_CODE_FLAG  <= 1'b0;
         oSET_CODE       <= '0;
         oTrigger        <= 1'b0;
         oErr            <= 1'b0;
         oCmd_count      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               oRx_ready <= 1'b1;
               if (take) begin
                  shreg    <= '0;
                  idle_cnt <= '0;
                  phase    <= '0;
                  case (iRx_data)
                     8'h01: begin
                        kind  <= K_IDX;
                        left  <= 3'd1;
                        state <= PAYLOAD;
                     end
                     8'h02: begin
                        kind  <= K_CODE;
                        left  <= 3'd4;
                        state <= PAYLOAD;
                     end
                     8'h03: begin
                        kind      <= K_TRIG;
                        state     <= SETUP;
                        oRx_ready <= 1'b0;
                     end
                     8'hFF:   oErr <= 1'b0;
                     default: oErr <= 1'b1;
                  endcase
               end
            end
            PAYLOAD: begin
               if (take) begin
                  shreg    <= shifted;
                  idle_cnt <= '0;
                  left     <= left - 3'd1;
                  if (left == 3'd1) begin
                     if (kind == K_IDX) oSET_INDEX <= iRx_data;
                     else               oSET_CODE  <= shifted;
                     state     <= SETUP;
                     phase     <= '0;
                     oRx_ready <= 1'b0;
                  end
               end else if (idle_cnt == T_LAST) begin
                  // stalled frame: drop it, data outputs untouched
                  state <= IDLE;
                  oErr  <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            SETUP: begin
               if (phase == S_LAST) begin
                  phase           <= '0;
                  state           <= PULSE;
                  oSET_INDEX_FLAG <= (kind == K_IDX);
                  oSET_CODE_FLAG  <= (kind == K_CODE);
                  oTrigger        <= (kind == K_TRIG);
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            PULSE: begin
               if (phase == P_LAST) begin
                  phase           <= '0;
                  state           <= HOLD;
                  oSET_INDEX_FLAG <= 1'b0;
                  oSET_CODE_FLAG  <= 1'b0;
                  oTrigger        <= 1'b0;
                  oCmd_count      <= oCmd_count + 16'd1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            HOLD: begin
               if (phase == H_LAST) begin
                  phase     <= '0;
                  state     <= IDLE;
                  oRx_ready <= 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
